// File: rtl/delay_sched_pkg.sv
// delay_sched shared types and helpers.
// Scheduler states and one-hot index encoder.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int MAXN = 16;

  function automatic logic [MAXN-1:0] onehot(
    input int idx,
    input int n
  );
    logic [MAXN-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n) r = MAXN'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/delay_sched_rr_arb.sv
// Combinational N-way round-robin picker.
// Search order is ptr, ptr+1, ... wrapping at N-1.
module rr_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] win
);

  logic [N-1:0] eff;
  logic [N-1:0] rot;
  int           pos;
  int           sum;

  assign eff = req & ~mask;
  assign rot = N'({eff, eff} >> ptr);

  // lowest set bit of the rotated vector is the first in search order
  always_comb begin
    valid = 1'b0;
    pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        pos   = i;
      end
    end
  end

  // map rotated position back to an absolute index, mod N
  always_comb begin
    sum = int'(ptr) + pos;
    if (sum >= N) sum = sum - N;
    win = IDW'(sum);
  end

endmodule

// File: rtl/delay_sched.sv
// Shared delay-timer scheduler: one down-counter,
// N round-robin clients, one-cycle done pulse.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      sclr,
  input  logic                      tick,
  input  logic [N-1:0]              req,
  input  logic [N-1:0][WIDTH-1:0]   delay,
  output logic [N-1:0]              gnt,
  output logic [N-1:0]              done,
  output logic                      busy,
  output logic [IDW-1:0]            cur_id,
  output logic [WIDTH-1:0]          remain
);

  state_t           st, st_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [IDW-1:0]   id_n;
  logic [N-1:0]     gnt_n, done_n;
  logic [WIDTH-1:0] rem_n;
  logic [N-1:0]     mask;
  logic [N-1:0]     cur_oh;
  logic [N-1:0]     win_oh;
  logic             av;
  logic [IDW-1:0]   aw;
  logic [IDW-1:0]   nid;

  assign nid    = (cur_id == IDW'(N - 1)) ? '0 : cur_id + IDW'(1);
  assign cur_oh = N'(onehot(int'(cur_id), N));
  assign win_oh = N'(onehot(int'(aw), N));
  assign mask   = (st == DONE) ? cur_oh : '0;
  assign busy   = (st == RUN);

  rr_arb #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr),
    .valid (av),
    .win   (aw)
  );

  // next-state and next-output decode; sclr overrides everything
  always_comb begin
    st_n   = st;
    gnt_n  = gnt;
    done_n = '0;
    ptr_n  = ptr;
    id_n   = cur_id;
    rem_n  = remain;
    unique case (st)
      IDLE, DONE: begin
        if (av) begin
          st_n  = RUN;
          gnt_n = win_oh;
          id_n  = aw;
          rem_n = delay[aw];
        end else begin
          st_n  = IDLE;
        end
      end
      RUN: begin
        if (!req[cur_id]) begin
          st_n  = IDLE;
          gnt_n = '0;
          ptr_n = nid;
        end else if (remain == '0) begin
          st_n   = DONE;
          gnt_n  = '0;
          done_n = cur_oh;
          ptr_n  = nid;
        end else if (tick) begin
          rem_n = remain - WIDTH'(1);
        end
      end
      default: st_n = IDLE;
    endcase
    if (sclr) begin
      st_n   = IDLE;
      gnt_n  = '0;
      done_n = '0;
      ptr_n  = '0;
      id_n   = '0;
      rem_n  = '0;
    end
  end

  // state, pointer and registered outputs
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      st     <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      done   <= '0;
      cur_id <= '0;
      remain <= '0;
    end else begin
      st     <= st_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      done   <= done_n;
      cur_id <= id_n;
      remain <= rem_n;
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched: directed
// vector table, corner sequences, random vs model.
module tb_delay_sched;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                    clk  = 1'b0;
  logic                    aclr = 1'b0;
  logic                    sclr = 1'b0;
  logic                    tick = 1'b0;
  logic [N-1:0]            req  = '0;
  logic [N-1:0][WIDTH-1:0] delay = '0;
  logic [N-1:0]            gnt;
  logic [N-1:0]            done;
  logic                    busy;
  logic [IDW-1:0]          cur_id;
  logic [WIDTH-1:0]        remain;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  delay_sched #(
    .N     (N),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk    (clk),
    .aclr   (aclr),
    .sclr   (sclr),
    .tick   (tick),
    .req    (req),
    .delay  (delay),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .cur_id (cur_id),
    .remain (remain)
  );

  // reference model: who owns the counter, how much is left,
  // and whether a completion is being announced this cycle
  int m_own  = -1;
  int m_last = 0;
  int m_rem  = 0;
  int m_ptr  = 0;
  bit m_ann  = 1'b0;

  always @(posedge clk or posedge aclr) begin
    if (aclr || sclr) begin
      m_own  = -1;
      m_last = 0;
      m_rem  = 0;
      m_ptr  = 0;
      m_ann  = 1'b0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_ptr = (m_last + 1) % N;
        m_own = -1;
      end else if (m_rem == 0) begin
        m_ptr = (m_last + 1) % N;
        m_own = -1;
        m_ann = 1'b1;
      end else if (tick) begin
        m_rem = m_rem - 1;
      end
    end else begin : pick_blk
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (pick < 0 && req[i] && !(m_ann && i == m_last))
          pick = i;
      end
      m_ann = 1'b0;
      if (pick >= 0) begin
        m_own  = pick;
        m_last = pick;
        m_rem  = int'(delay[pick]);
      end
    end
  end

  // compare every cycle against the model, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] eg, ed;
      eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
      ed = m_ann ? (N'(1) << m_last) : '0;
      checks++;
      if (gnt !== eg || done !== ed || busy !== (m_own >= 0) ||
          cur_id !== IDW'(m_last) || remain !== WIDTH'(m_rem)) begin
        failures++;
        $display("FAIL model t=%0t act gnt=%b done=%b busy=%b id=%0d rem=%0d exp gnt=%b done=%b busy=%b id=%0d rem=%0d",
                 $time, gnt, done, busy, cur_id, remain,
                 eg, ed, (m_own >= 0), m_last, m_rem);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aclr();
    step();
    aclr = 1'b1;
    sclr = 1'b0;
    tick = 1'b0;
    req  = '0;
    #1;
    aclr = 1'b0;
  endtask

  typedef struct {
    int idx;
    int dly;
    int per;
    int exp;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int           dc;
    logic [N-1:0] g1, dv;
    logic         bz;
    do_aclr();
    dc = -1;
    g1 = '0;
    dv = '0;
    bz = 1'b1;
    delay[v.idx] = WIDTH'(v.dly);
    req[v.idx]   = 1'b1;
    tick = (v.per == 1);
    for (int c = 1; c <= 200 && dc < 0; c++) begin
      step();
      if (c == 1) g1 = gnt;
      if (done != '0) begin
        dc  = c;
        dv  = done;
        bz  = busy;
        req = '0;
      end
      tick = ((c % v.per) == v.per - 1);
    end
    chk("vec_gnt", 32'(g1), 32'(N'(1) << v.idx));
    chk("vec_done_cycle", dc, v.exp);
    chk("vec_done_vec", 32'(dv), 32'(N'(1) << v.idx));
    chk("vec_busy_at_done", 32'(bz), 0);
    step();
    chk("vec_done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int st[N];
    int cn[N];
    tbl[0] = '{idx: 2, dly: 5,  per: 1, exp: 7};
    tbl[1] = '{idx: 0, dly: 0,  per: 1, exp: 2};
    tbl[2] = '{idx: 3, dly: 3,  per: 4, exp: 13};
    tbl[3] = '{idx: 1, dly: 1,  per: 1, exp: 3};
    tbl[4] = '{idx: 0, dly: 10, per: 2, exp: 21};
    tbl[5] = '{idx: 1, dly: 2,  per: 3, exp: 7};

    #3 aclr = 1'b1;
    #20 aclr = 1'b0;
    chk("reset_outs", {gnt, done, busy, cur_id, remain}, 0);
    chk_en = 1'b1;

    foreach (tbl[k]) run_vec(tbl[k]);

    // contention: all four wait, grants rotate 0..3
    do_aclr();
    for (int i = 0; i < N; i++) begin
      delay[i] = WIDTH'(2);
      st[i] = -1;
      cn[i] = 0;
    end
    req  = '1;
    tick = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          cn[i]++;
          if (st[i] < 0) st[i] = c;
        end
      end
      req = req & ~done;
    end
    for (int i = 0; i < N; i++) begin
      chk("rr_start", st[i], 1 + 4 * i);
      chk("rr_len", cn[i], 3);
    end

    // abort: drop req[1] at remain=4, grant moves to 2
    do_aclr();
    delay[1] = WIDTH'(6);
    delay[2] = WIDTH'(6);
    req  = 4'b0110;
    tick = 1'b1;
    step();
    chk("ab_gnt1", 32'(gnt), 32'h2);
    step();
    step();
    chk("ab_rem4", 32'(remain), 4);
    req[1] = 1'b0;
    step();
    chk("ab_gnt_clr", 32'(gnt), 0);
    chk("ab_no_done", 32'(done), 0);
    step();
    chk("ab_next_gnt", 32'(gnt), 32'h4);
    chk("ab_no_done2", 32'(done), 0);
    req = '0;

    // aclr mid-run at remain=7
    do_aclr();
    delay[3] = WIDTH'(10);
    req  = 4'b1000;
    tick = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("ac_rem7", 32'(remain), 7);
    aclr = 1'b1;
    req  = '0;
    #1;
    chk("ac_outs_zero", {gnt, done, busy, cur_id, remain}, 0);
    #1 aclr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ac_no_done", 32'(done), 0);
    end

    // sclr during DONE: ptr returns to 0, requester 0 wins
    do_aclr();
    delay[1] = WIDTH'(0);
    delay[2] = WIDTH'(5);
    delay[0] = WIDTH'(3);
    req  = 4'b0110;
    tick = 1'b1;
    step();
    chk("sc_gnt1", 32'(gnt), 32'h2);
    step();
    chk("sc_done1", 32'(done), 32'h2);
    sclr = 1'b1;
    req  = 4'b0101;
    step();
    chk("sc_done_clr", {gnt, done, busy}, 0);
    sclr = 1'b0;
    step();
    chk("sc_gnt0", 32'(gnt), 32'h1);
    chk("sc_id0", 32'(cur_id), 0);

    // random traffic against the model
    do_aclr();
    for (int c = 0; c < 3000; c++) begin
      step();
      tick = ($urandom % 3) != 0;
      sclr = ($urandom % 200) == 0;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom % 25 == 0) req[i] = 1'b0;
          if ($urandom % 10 == 0) delay[i] = WIDTH'($urandom % 8);
        end else if ($urandom % 4 == 0) begin
          delay[i] = WIDTH'($urandom % 8);
          req[i]   = 1'b1;
        end
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
